// File: rtl/data_mem_arb_pkg.sv
// Shared constants and types for the data memory arbiter: microcode memory-control
// codes, arbiter FSM encoding and access ownership.
package data_mem_arb_pkg;

    localparam logic [1:0] MCTL_NONE    = 2'b00;
    localparam logic [1:0] MCTL_READ    = 2'b01;
    localparam logic [1:0] MCTL_WRITE   = 2'b10;
    localparam logic [1:0] MCTL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    function automatic logic is_core_req(input logic [1:0] mctl);
        return (mctl == MCTL_READ) || (mctl == MCTL_WRITE);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the core, host and memory-side signals around the data memory arbiter.
// slave = arbiter side, master = surrounding system (sequencer, host, RAM).
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        core_mctl;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              core_done;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              illegal_op;

    modport slave (
        input  core_mctl, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_rdata, core_stall, core_done,
        output host_gnt, host_rdata, host_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output illegal_op
    );

    modport master (
        output core_mctl, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_rdata, core_stall, core_done,
        input  host_gnt, host_rdata, host_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  illegal_op
    );
endinterface

// File: rtl/mem_lat_timer.sv
// Loadable down-counter timing the memory access; last flags the final ACCESS cycle.
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MEM_LAT - 1);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = en && (count == '0);

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises core (microcode) and host accesses to the single-port data RAM,
// times the memory latency and returns read data to the access owner.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clock,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state, state_d;
    owner_t            owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] core_rdata_q, host_rdata_q;
    logic [SC_W-1:0]   starve;
    logic              illegal_q;

    logic core_req, starved, grant_core, grant_host, last_cycle;
    logic core_done_w, host_done_w, in_access;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (grant_core | grant_host),
        .en    (in_access),
        .last  (last_cycle)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        core_req    = is_core_req(bus.core_mctl);
        starved     = (starve == SC_W'(STARVE_LIMIT));
        grant_core  = 1'b0;
        grant_host  = 1'b0;
        state_d     = state;
        in_access   = (state == ACCESS);
        core_done_w = (state == DONE) && (owner == OWN_CORE);
        host_done_w = (state == DONE) && (owner == OWN_HOST);

        case (state)
            IDLE: begin
                // Host wins only when the core is quiet or has used up its starve budget.
                if (bus.host_req && (!core_req || starved)) begin
                    grant_host = 1'b1;
                    state_d    = ACCESS;
                end else if (core_req) begin
                    grant_core = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS:  if (last_cycle) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        bus.mem_en     = in_access;
        bus.mem_we     = in_access && lat_we;
        bus.mem_addr   = in_access ? lat_addr  : '0;
        bus.mem_wdata  = in_access ? lat_wdata : '0;
        bus.core_done  = core_done_w;
        bus.host_done  = host_done_w;
        bus.core_stall = core_req && !core_done_w;
        bus.host_gnt   = (state != IDLE) && (owner == OWN_HOST);
        bus.core_rdata = core_rdata_q;
        bus.host_rdata = host_rdata_q;
        bus.illegal_op = illegal_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner        <= OWN_NONE;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
            starve       <= '0;
            illegal_q    <= 1'b0;
        end else begin
            if (bus.core_mctl == MCTL_ILLEGAL) illegal_q <= 1'b1;

            if (grant_core) begin
                owner     <= OWN_CORE;
                lat_we    <= (bus.core_mctl == MCTL_WRITE);
                lat_addr  <= bus.core_addr;
                lat_wdata <= bus.core_wdata;
                if (bus.host_req && !starved) starve <= starve + 1'b1;
            end

            if (grant_host) begin
                owner     <= OWN_HOST;
                lat_we    <= bus.host_we;
                lat_addr  <= bus.host_addr;
                lat_wdata <= bus.host_wdata;
                starve    <= '0;
            end

            if ((state == IDLE) && !bus.host_req) starve <= '0;

            // Read data is captured on the final ACCESS edge and held until the next read.
            if (in_access && last_cycle && !lat_we) begin
                if (owner == OWN_HOST) host_rdata_q <= bus.mem_rdata;
                else                   core_rdata_q <= bus.mem_rdata;
            end

            if (state == DONE) owner <= OWN_NONE;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a vector table of single transactions plus
// hand-written sequences for starvation, contention, reset abort and illegal codes.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    localparam int MEM_LAT      = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int LAT_EXP      = MEM_LAT + 1;
    localparam int BOUND        = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: data is only presented on the MEM_LAT-th enabled cycle, 0xEE otherwise.
    logic [7:0] mem [256];
    int en_cycles = 0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h12] <= 8'hA5;
            mem[8'hFF] <= 8'h77;
            en_cycles  <= 0;
        end else begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            en_cycles <= bus.mem_en ? en_cycles + 1 : 0;
        end
    end

    assign bus.mem_rdata = (bus.mem_en && !bus.mem_we && en_cycles == MEM_LAT - 1)
                           ? mem[bus.mem_addr] : 8'hEE;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_mctl  = MCTL_NONE;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " flags"},
              {25'd0, bus.mem_en, bus.mem_we, bus.core_done, bus.host_done,
               bus.core_stall, bus.host_gnt, bus.illegal_op}, 32'd0);
        check({tag, " buses"},
              {bus.mem_addr, bus.mem_wdata, bus.core_rdata, bus.host_rdata}, 32'd0);
    endtask

    // One isolated transaction; called at posedge+1 of an IDLE cycle, returns at
    // posedge+1 of the cycle after done with requests dropped.
    task automatic run_txn(input bit host, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, output int lat, output int en_cnt,
                           output bit side_ok, output logic [7:0] rd);
        bit done_now;
        lat = 0; en_cnt = 0; side_ok = 1'b1; rd = 8'hXX; done_now = 1'b0;
        if (host) begin
            bus.host_req = 1'b1; bus.host_we = we;
            bus.host_addr = addr; bus.host_wdata = wdata;
        end else begin
            bus.core_mctl = we ? MCTL_WRITE : MCTL_READ;
            bus.core_addr = addr; bus.core_wdata = wdata;
        end
        while (lat <= BOUND) begin
            #1;
            done_now = host ? bus.host_done : bus.core_done;
            if (bus.mem_en) en_cnt++;
            if (bus.core_stall !== (!host && !done_now)) side_ok = 1'b0;
            if (bus.host_gnt !== (host && lat > 0)) side_ok = 1'b0;
            if (done_now) begin
                rd = host ? bus.host_rdata : bus.core_rdata;
                break;
            end
            @(posedge clock);
            lat++;
        end
        idle_inputs();
        cyc();
    endtask

    typedef struct {
        bit         host;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int         lat, en_cnt, ncore, t_core, t_gnt, t_hdone, pulses;
        bit         side_ok, got;
        logic [7:0] rd;

        // Writes leave the owner's rdata at its previous read value.
        vecs[0] = '{1'b0, 1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h30, 8'h5C, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h5C};
        vecs[3] = '{1'b0, 1'b1, 8'h40, 8'h3C, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 8'h40, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h77};
        vecs[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'hA5};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};

        idle_inputs();
        reset = 1'b1;
        cyc(); cyc();
        check_all_zero("reset");
        reset = 1'b0;
        cyc();

        foreach (vecs[i]) begin
            run_txn(vecs[i].host, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, en_cnt, side_ok, rd);
            check($sformatf("vec%0d latency", i), lat, LAT_EXP);
            check($sformatf("vec%0d mem_en cycles", i), en_cnt, MEM_LAT);
            check($sformatf("vec%0d stall/gnt", i), side_ok, 1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d done cleared", i), {bus.core_done, bus.host_done}, 0);
            if (vecs[i].we) check($sformatf("vec%0d mem write", i), mem[vecs[i].addr], vecs[i].wdata);
        end

        // Core streams reads while host waits: STARVE_LIMIT core grants, then host, twice.
        bus.core_mctl = MCTL_READ; bus.core_addr = 8'h40;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h12;
        for (int round = 0; round < 2; round++) begin
            ncore = 0; got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                #1;
                if (bus.core_done) ncore++;
                if (bus.host_gnt) got = 1'b1;
                else @(posedge clock);
            end
            check($sformatf("starve r%0d host granted", round), got, 1);
            check($sformatf("starve r%0d core grants", round), ncore, STARVE_LIMIT);
            got = 1'b0;
            for (int c = 0; c < BOUND && !got; c++) begin
                if (bus.host_done) got = 1'b1;
                else cyc();
            end
            check($sformatf("starve r%0d host done", round), got, 1);
            check($sformatf("starve r%0d host rdata", round), bus.host_rdata, 8'hA5);
            @(posedge clock);
        end
        #1;
        idle_inputs();
        cyc(); cyc();

        // Both request with starve clear: core first, host in the IDLE right after core_done.
        bus.core_mctl = MCTL_READ; bus.core_addr = 8'h40;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h30;
        t_core = -1; t_gnt = -1; t_hdone = -1;
        for (int c = 0; c < BOUND && t_hdone < 0; c++) begin
            #1;
            if (bus.core_done && t_core < 0) begin
                t_core = c;
                check("contend core rdata", bus.core_rdata, 8'h3C);
                bus.core_mctl = MCTL_NONE;
            end
            if (bus.host_gnt && t_gnt < 0) t_gnt = c;
            if (bus.host_done) begin
                t_hdone = c;
                check("contend host rdata", bus.host_rdata, 8'h5C);
                bus.host_req = 1'b0;
            end
            @(posedge clock);
        end
        check("contend core done cycle", t_core, LAT_EXP);
        check("contend host gnt cycle", t_gnt, LAT_EXP + 2);
        check("contend host done cycle", t_hdone, 2 * LAT_EXP + 1);
        #1;
        idle_inputs();
        cyc();

        // Reset during ACCESS aborts the access without a done pulse.
        bus.core_mctl = MCTL_READ; bus.core_addr = 8'h12;
        cyc();
        check("abort in access", bus.mem_en, 1);
        reset = 1'b1;
        bus.core_mctl = MCTL_NONE;
        cyc();
        check_all_zero("abort reset");
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (bus.core_done || bus.host_done || bus.mem_en) pulses++;
        end
        check("abort no done", pulses, 0);
        run_txn(1'b0, 1'b0, 8'h12, 8'h00, lat, en_cnt, side_ok, rd);
        check("after abort latency", lat, LAT_EXP);
        check("after abort rdata", rd, 8'hA5);

        // Illegal code: no access, no stall, sticky flag until reset.
        bus.core_mctl = MCTL_ILLEGAL;
        #1;
        check("illegal no stall", bus.core_stall, 0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (bus.mem_en || bus.core_stall) pulses++;
        end
        check("illegal no access", pulses, 0);
        check("illegal_op set", bus.illegal_op, 1);
        bus.core_mctl = MCTL_NONE;
        cyc(); cyc(); cyc();
        check("illegal_op sticky", bus.illegal_op, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("illegal_op cleared", bus.illegal_op, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
